// File: rtl/seq_6bit_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a start/done handshake.
// The trial subtract reuses the adder form X + ~Y + 1, where carry-out = 1 means no borrow.
module seq_6bit_divider #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic             carry;

    // Shifted partial remainder and trial subtract; R is one bit wider so the shift never truncates.
    always_comb begin
        rs            = (WIDTH + 1)'({r_q, q_q[WIDTH-1]});
        {carry, diff} = {1'b0, rs} + {1'b0, ~{1'b0, d_q}} + (WIDTH + 2)'(1);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        q_d         = q_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            CALC: begin
                r_d   = carry ? diff : rs;
                q_d   = {q_q[WIDTH-2:0], carry};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quotient_d  = q_d;
                    remainder_d = r_d[WIDTH-1:0];
                    state_d     = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so no output can ever start as X.
            state_q     <= IDLE;
            cnt_q       <= '0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            q_q         <= q_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_6bit_divider.sv
// Scoreboarded bench for seq_6bit_divider: the driver pushes expected results from a plain
// arithmetic model, and an independent monitor pops and compares on every done pulse.
module tb_seq_6bit_divider;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_6bit_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned division; a zero divisor yields all-ones and the dividend.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.cyc = 0;
        if (b == 0) begin
            e.q   = 6'd63;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(mon_e.q));
                check("remainder", 32'(remainder), 32'(mon_e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
                check("busy_with_done", 32'(busy), 32'd1);
                check("latency", 32'(cyc - mon_e.cyc), mon_e.dbz ? 32'd1 : 32'd7);
                if (!mon_e.dbz) begin
                    check("invariant", 32'(quotient) * 32'(mon_e.b) + 32'(remainder), 32'(mon_e.a));
                    check("rem_lt_div", 32'(remainder < mon_e.b), 32'd1);
                end
            end
        end
    end

    // Entered and left just after a falling edge; waits for IDLE, then presents one request.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input bit noise);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy) begin
            if (noise && $urandom_range(0, 2) == 0) begin
                start    = 1'b1;
                dividend = 6'($urandom);
                divisor  = 6'($urandom);
            end else if (!hold) begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                check("idle_timeout", 32'(busy), 32'd0);
                start = 1'b0;
                return;
            end
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e        = model(a, b);
        e.cyc    = cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           n;
        exp_t         e;
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rh;

        ta = '{6'd63, 6'd5, 6'd63};
        tb = '{6'd1, 6'd9, 6'd63};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 45/6 with busy-duration check
        issue(6'd45, 6'd6, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd7);
        wait_drain();

        // Boundary cases and result hold while idle
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], 1'b0, 1'b0);
            wait_drain();
            e = model(ta[i], tb[i]);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("hold_quotient", 32'(quotient), 32'(e.q));
                check("hold_remainder", 32'(remainder), 32'(e.r));
                check("hold_busy", 32'(busy), 32'd0);
            end
        end

        // Divide by zero, then a normal divide clears the flag
        issue(6'd20, 6'd0, 1'b0, 1'b0);
        wait_drain();
        issue(6'd20, 6'd3, 1'b0, 1'b0);
        wait_drain();

        // A start pulse during CALC is ignored
        issue(6'd50, 6'd7, 1'b0, 1'b0);
        @(negedge clk);
        dividend = 6'd9;
        divisor  = 6'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (12) @(negedge clk);
        check("ignored_start_queue", 32'(sb.size()), 32'd0);

        // Reset on the third CALC edge aborts the operation without a done
        issue(6'd40, 6'd5, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(6'd40, 6'd5, 1'b0, 1'b0);
        wait_drain();

        // Exhaustive sweep with start held high (back-to-back operations)
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                issue(6'(a), 6'(b), 1'b1, 1'b0);
            end
        end
        start = 1'b0;
        wait_drain();

        // Random operands, random holding, and spurious starts while busy
        for (int i = 0; i < 300; i++) begin
            ra = 6'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            rh = 1'($urandom_range(0, 1));
            issue(ra, rb, rh, 1'b1);
            if (!rh && $urandom_range(0, 3) == 0) begin
                wait_drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
